// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: multi-output PWM sharing one prescaled edge/center-aligned timebase,
// with double-buffered period/duty/mode that commit only at a period boundary.
module pwm_multi_channel #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int PRESCALE_W = 8,
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  center_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  period_wr,
    input  logic [WIDTH-1:0]      period_in,
    input  logic                  duty_wr,
    input  logic [SEL_W-1:0]      duty_sel,
    input  logic [WIDTH-1:0]      duty_in,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  cycle_start,
    output logic                  update_pending
);
    localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(CHANNELS);

    logic [PRESCALE_W-1:0] pre;
    logic [WIDTH-1:0]      cnt, cnt_nxt, per_act, per_sh;
    logic [WIDTH-1:0]      duty_act [CHANNELS];
    logic [WIDTH-1:0]      duty_sh  [CHANNELS];
    logic                  dir_dn, dir_nxt, mode_act;
    logic                  tick, bnd, duty_ok, wr_acc;

    // Center mode bounces 0..P..1; P = 0 makes every tick a boundary.
    always_comb begin
        tick    = enable && pre == prescale;
        bnd     = tick && (mode_act ? (per_act == '0 || (dir_dn && cnt == WIDTH'(1)))
                                    : cnt == per_act);
        cnt_nxt = (mode_act && dir_dn) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
        dir_nxt = dir_dn || (mode_act && cnt_nxt == per_act);
        duty_ok = duty_wr && {1'b0, duty_sel} < NUM_CH;
        wr_acc  = period_wr || duty_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre            <= '0;
            cnt            <= '0;
            dir_dn         <= 1'b0;
            per_act        <= '1;
            per_sh         <= '1;
            mode_act       <= 1'b0;
            update_pending <= 1'b0;
            cycle_start    <= 1'b0;
            pwm_out        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
                duty_sh[i]  <= '0;
            end
        end else begin
            pre    <= (!enable || tick) ? '0 : pre + PRESCALE_W'(1);
            cnt    <= (!enable || bnd) ? '0 : tick ? cnt_nxt : cnt;
            dir_dn <= (!enable || bnd) ? 1'b0 : tick ? dir_nxt : dir_dn;
            if (period_wr)
                per_sh <= period_in;
            // While idle, the active set tracks shadow including a same-clock write.
            if (!enable)
                per_act <= period_wr ? period_in : per_sh;
            else if (bnd)
                per_act <= per_sh;
            if (!enable || bnd)
                mode_act <= center_mode;
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_wr && duty_sel == SEL_W'(i))
                    duty_sh[i] <= duty_in;
                if (!enable)
                    duty_act[i] <= (duty_wr && duty_sel == SEL_W'(i)) ? duty_in : duty_sh[i];
                else if (bnd)
                    duty_act[i] <= duty_sh[i];
                pwm_out[i] <= enable && cnt < duty_act[i];
            end
            update_pending <= enable && (wr_acc || (update_pending && !bnd));
            cycle_start    <= bnd;
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: scoreboard bench; a closed-form timebase model predicts each clock's outputs.
module tb_pwm_multi_channel;
    localparam int W  = 8;
    localparam int CH = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          center_mode = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          period_wr = 1'b0;
    logic [W-1:0]  period_in = '0;
    logic          duty_wr = 1'b0;
    logic [1:0]    duty_sel = '0;
    logic [W-1:0]  duty_in = '0;
    logic [CH-1:0] pwm_out;
    logic          cycle_start;
    logic          update_pending;

    pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .center_mode(center_mode),
        .prescale(prescale), .period_wr(period_wr), .period_in(period_in),
        .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_in(duty_in),
        .pwm_out(pwm_out), .cycle_start(cycle_start), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          cs;
        logic          pend;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: c = clocks since the period (or enable) started; active/shadow copies.
    int   c;
    int   m_per, s_per;
    bit   m_mode, m_pend;
    int   m_duty[CH];
    int   s_duty[CH];
    int   hi[CH];
    int   ncs;

    function automatic int cnt_at(int j);
        int k = j / (int'(prescale) + 1);
        if (m_mode) begin
            if (m_per == 0) return 0;
            k = k % (2 * m_per);
            return (k <= m_per) ? k : 2 * m_per - k;
        end
        return k % (m_per + 1);
    endfunction

    function automatic void model_reset();
        c = 0; s_per = 255; m_per = 255; m_mode = 0; m_pend = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            s_duty[i] = 0;
        end
    endfunction

    function automatic void clr_obs();
        ncs = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
    endfunction

    task automatic step(input string tag);
        exp_t e, got;
        e = '0;
        if (enable) begin
            c++;
            for (int i = 0; i < CH; i++) e.pwm[i] = cnt_at(c - 1) < m_duty[i];
            e.cs = (c % (int'(prescale) + 1) == 0) && cnt_at(c) == 0;
            if (e.cs) begin
                m_duty = s_duty; m_per = s_per; m_mode = center_mode; m_pend = 0; c = 0;
            end
            if (period_wr) begin s_per = int'(period_in); m_pend = 1; end
            if (duty_wr && duty_sel < CH) begin s_duty[duty_sel] = int'(duty_in); m_pend = 1; end
            e.pend = m_pend;
        end else begin
            c = 0;
            if (period_wr) s_per = int'(period_in);
            if (duty_wr && duty_sel < CH) s_duty[duty_sel] = int'(duty_in);
            m_duty = s_duty; m_per = s_per; m_mode = center_mode; m_pend = 0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {pwm_out, cycle_start, update_pending};
        e = sb.pop_front();
        vectors++;
        if (got.pwm !== e.pwm) begin
            miscompares++;
            $display("FAIL %s pwm_out got %b want %b at %0t", tag, got.pwm, e.pwm, $time);
        end
        vectors++;
        if (got.cs !== e.cs) begin
            miscompares++;
            $display("FAIL %s cycle_start got %b want %b at %0t", tag, got.cs, e.cs, $time);
        end
        vectors++;
        if (got.pend !== e.pend) begin
            miscompares++;
            $display("FAIL %s update_pending got %b want %b at %0t", tag, got.pend, e.pend, $time);
        end
        for (int i = 0; i < CH; i++) hi[i] += int'(got.pwm[i]);
        ncs += int'(got.cs);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic wr_duty(input int ch, input int val, input string tag);
        duty_wr = 1'b1; duty_sel = 2'(ch); duty_in = W'(val);
        step(tag);
        duty_wr = 1'b0;
    endtask

    task automatic wr_period(input int val, input string tag);
        period_wr = 1'b1; period_in = W'(val);
        step(tag);
        period_wr = 1'b0;
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s count got %0d want %0d", tag, got, want);
        end
    endtask

    // Idle, then program edge/center mode, prescale, period and three duties.
    task automatic setup(input bit mode, input int ps, input int p, input int d0, input int d1, input int d2);
        enable = 1'b0; center_mode = mode; prescale = PW'(ps);
        step("setup");
        wr_period(p, "setup");
        wr_duty(0, d0, "setup");
        wr_duty(1, d1, "setup");
        wr_duty(2, d2, "setup");
        enable = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({pwm_out, cycle_start, update_pending} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs got %b want 0", {pwm_out, cycle_start, update_pending});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(3, "reset_idle");
    endtask

    task automatic test_edge();
        setup(1'b0, 0, 9, 3, 0, 10);
        run(10, "edge");
        clr_obs();
        run(10, "edge");
        check_count("edge_hi0", hi[0], 3);
        check_count("edge_hi1_d0", hi[1], 0);
        check_count("edge_hi2_dover", hi[2], 10);
        check_count("edge_cs", ncs, 1);
        run(10, "edge");
    endtask

    task automatic test_center();
        setup(1'b1, 0, 4, 0, 2, 5);
        clr_obs();
        run(8, "center");
        check_count("center_hi1", hi[1], 3);
        check_count("center_cs", ncs, 1);
        run(8, "center");
        setup(1'b1, 2, 4, 0, 2, 5);
        clr_obs();
        run(24, "center_ps2");
        check_count("center_ps2_hi1", hi[1], 9);
        check_count("center_ps2_cs", ncs, 1);
        run(10, "center_ps2");
    endtask

    task automatic test_update();
        setup(1'b0, 0, 9, 3, 1, 0);
        run(13, "update");
        wr_duty(0, 7, "update_wr");
        clr_obs();
        run(6, "update");
        clr_obs();
        run(10, "update");
        check_count("update_hi0", hi[0], 7);
    endtask

    task automatic test_boundary_write();
        setup(1'b0, 0, 9, 3, 0, 0);
        run(5, "bwr");
        for (int k = 0; k < 20 && c != 9; k++) step("bwr_align");
        wr_duty(0, 5, "bwr_coincident");
        run(25, "bwr");
        wr_duty(3, 9, "bwr_badsel");
        run(12, "bwr_badsel");
    endtask

    task automatic test_enable_drop();
        setup(1'b0, 0, 9, 4, 6, 2);
        run(12, "endrop");
        enable = 1'b0;
        run(4, "endrop_idle");
        wr_duty(1, 8, "endrop_idle_wr");
        enable = 1'b1;
        run(22, "endrop_resume");
    endtask

    task automatic test_back_to_back();
        setup(1'b0, 1, 5, 2, 3, 4);
        run(5, "b2b");
        wr_duty(0, 5, "b2b_wr");
        wr_duty(1, 1, "b2b_wr");
        wr_period(7, "b2b_wr");
        run(40, "b2b");
    endtask

    task automatic test_reset_mid();
        setup(1'b0, 0, 9, 3, 3, 3);
        run(2, "rstmid");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pwm_out, cycle_start, update_pending} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid outputs got %b want 0", {pwm_out, cycle_start, update_pending});
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(5, "rstmid_after");
        setup(1'b0, 0, 9, 3, 3, 3);
        run(20, "rstmid_restart");
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_update();
        test_boundary_write();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator: successor to the single-channel PWM block, with CHANNELS outputs sharing one timebase. It adds a runtime prescaler, edge- or center-aligned counting, and double-buffered period/duty registers that commit only at a period boundary, so reprogramming never produces a runt or glitched pulse. It sits between the register interface and motor/LED drivers.

## Interface
- WIDTH, 8, counter/period/duty resolution
- CHANNELS, 4, number of PWM outputs (1..16)
- PRESCALE_W, 8, prescaler control width
- SEL_W, derived: max(1, $clog2(CHANNELS)); not user-set
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run timebase; low holds it idle and forces outputs low
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at boundaries only
- prescale  in  PRESCALE_W  timebase tick every prescale+1 clocks
- period_wr  in  1  write strobe for shadow period
- period_in  in  WIDTH  period value P
- duty_wr  in  1  write strobe for one shadow duty
- duty_sel  in  SEL_W  channel index for duty_wr
- duty_in  in  WIDTH  duty value D
- pwm_out  out  CHANNELS  registered PWM outputs
- cycle_start  out  1  one-clock pulse at each new PWM period
- update_pending  out  1  shadow differs from active, awaiting boundary

## Operation
- Reset: prescaler 0, counter 0, direction up, active/shadow period all-ones, active/shadow duties 0, active mode edge, pending 0, pwm_out 0, cycle_start 0.
- Prescaler: counts 0..prescale while enable; tick when count == prescale, then wraps to 0. prescale = 0 -> tick every clock. prescale is used live, not buffered.
- Edge mode: on tick counter 0,1,..,P, then 0; period = P+1 ticks.
- Center mode: on tick counter 0,1,..,P,P-1,..,1, then 0; period = 2P ticks. Direction flips to down on reaching P and to up on reaching 0. P = 0: counter stays 0, every tick is a boundary.
- Boundary: the tick on which the counter returns to 0. At a boundary: active period, all active duties, and active mode load from shadow/center_mode; pending clears; counter and direction restart at 0/up.
- Channel compare: pwm_out[i] = enable & (counter < D_active[i]). D = 0 -> constant low; D > P -> constant high. All comparisons unsigned, WIDTH bits.
- Writes: period_wr loads shadow period; duty_wr loads shadow duty[duty_sel]; duty_sel >= CHANNELS ignored (no pending set). Any accepted write sets pending.
- Write coincident with boundary: active loads the pre-write shadow; the new write stays in shadow, pending remains 1 for the next boundary.
- enable low: prescaler, counter, direction held at 0/up; pwm_out 0; cycle_start 0; accepted writes and center_mode transfer to active on the next clock, with pending 0.
- enable rising: counting starts from 0 using the active values; first cycle_start at the first boundary.

## Timing
- pwm_out is registered: it reflects the counter value one clock earlier.
- cycle_start is high for exactly one clock, the clock after the boundary tick.
- update_pending rises the clock after an accepted write and falls the clock after the committing boundary.
- A write reaches pwm_out no earlier than the first clock of the next period; never mid-period.
- rst_n assertion mid-period: all state returns to reset values immediately. After deassertion, the period restarts from 0 on the first rising clk edge.

## Test plan
- Edge, prescale 0, P = 9, D[0] = 3 -> pwm_out[0] high 3 clocks of every 10; cycle_start every 10 clocks.
- Center, P = 4, D[1] = 2 -> 8-clock period, pwm_out[1] high 3 clocks, centred on the counter-zero point; prescale 2 -> 24-clock period.
- Running with P = 9, D[0] = 3: write D[0] = 7 mid-period -> current period keeps 3 high; next period 7 high; update_pending high for exactly the intervening clocks.
- D = 0 and D = 10 with P = 9 -> pwm_out constant 0 and constant 1 respectively, no glitch across boundaries.
- Write coincident with boundary tick -> commits one period later. duty_sel = CHANNELS -> ignored, pending stays 0.
- rst_n low mid-period, or enable dropped -> pwm_out 0 the next clock; on recovery, counter restarts at 0 with the expected waveform.
